// File: rtl/lock_event_monitor.sv
`timescale 1ns/1ps
// lock_event_monitor: synchronizes and debounces an MMCM/PLL lock line and
// keeps unlock-episode statistics (count, last and longest duration).
module lock_event_monitor #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_WIDTH       = 32
) (
  input  logic                 clk_ref,
  input  logic                 aresetn,
  input  logic                 locked_async,
  input  logic                 clear,
  output logic                 locked_filt,
  output logic [CNT_WIDTH-1:0] unlocks,
  output logic [CNT_WIDTH-1:0] last_unlock_len,
  output logic [CNT_WIDTH-1:0] max_unlock_len,
  output logic                 ever_locked,
  output logic                 unlock_evt,
  output logic                 relock_evt
);
  typedef enum logic [1:0] {S_INIT, S_LOCKED, S_UNLOCKED} state_t;
  localparam logic [CNT_WIDTH-1:0] ALL_ONES = '1;
  localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic [15:0]            db_cnt;
  logic                   filt_d;
  logic                   rise;
  logic                   fall;
  state_t                 state;
  logic [CNT_WIDTH-1:0]   dur_cnt;
  assign sync = sync_q[SYNC_STAGES-1];
  assign rise = locked_filt & ~filt_d;
  assign fall = ~locked_filt & filt_d;
  // Events coincident with clear are applied on top of the cleared values.
  always_ff @(posedge clk_ref or negedge aresetn) begin
    if (!aresetn) begin
      sync_q          <= '0;
      db_cnt          <= '0;
      locked_filt     <= 1'b0;
      filt_d          <= 1'b0;
      state           <= S_INIT;
      dur_cnt         <= '0;
      unlocks         <= '0;
      last_unlock_len <= '0;
      max_unlock_len  <= '0;
      ever_locked     <= 1'b0;
      unlock_evt      <= 1'b0;
      relock_evt      <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], locked_async};
      filt_d     <= locked_filt;
      unlock_evt <= 1'b0;
      relock_evt <= 1'b0;
      if (sync == locked_filt) db_cnt <= '0;
      else if (db_cnt == DB_LAST) begin
        db_cnt      <= '0;
        locked_filt <= ~locked_filt;
      end else db_cnt <= db_cnt + 16'd1;
      if (clear) begin
        unlocks         <= '0;
        last_unlock_len <= '0;
        max_unlock_len  <= '0;
      end
      case (state)
        S_INIT: if (rise) begin
          state       <= S_LOCKED;
          ever_locked <= 1'b1;
        end
        S_LOCKED: if (fall) begin
          state      <= S_UNLOCKED;
          unlocks    <= clear ? CNT_WIDTH'(1) : (unlocks == ALL_ONES ? ALL_ONES : unlocks + 1'b1);
          unlock_evt <= 1'b1;
          dur_cnt    <= CNT_WIDTH'(1);
        end
        S_UNLOCKED: if (rise) begin
          state           <= S_LOCKED;
          last_unlock_len <= dur_cnt;
          max_unlock_len  <= (clear || dur_cnt > max_unlock_len) ? dur_cnt : max_unlock_len;
          relock_evt      <= 1'b1;
        end else if (dur_cnt != ALL_ONES) dur_cnt <= dur_cnt + 1'b1;
        default: state <= S_INIT;
      endcase
    end
  end
endmodule

// File: tb/tb_lock_event_monitor.sv
`timescale 1ns/1ps
// tb_lock_event_monitor: directed vectors for lock_event_monitor, plus a
// narrow-counter instance for saturation.
module tb_lock_event_monitor;
  logic clk_ref = 1'b0;
  logic aresetn = 1'b0;
  logic locked_async = 1'b0;
  logic clear = 1'b0;
  logic locked_filt, ever_locked, unlock_evt, relock_evt;
  logic [31:0] unlocks, last_unlock_len, max_unlock_len;
  logic la2 = 1'b0;
  logic clr2 = 1'b0;
  logic filt2, ever2, uevt2, revt2;
  logic [3:0] unl2, last2, max2;
  int tests = 0, fails = 0, n_unl = 0, n_rel = 0, n_unl2 = 0, n_rel2 = 0;

  lock_event_monitor dut (
    .clk_ref(clk_ref), .aresetn(aresetn), .locked_async(locked_async), .clear(clear),
    .locked_filt(locked_filt), .unlocks(unlocks), .last_unlock_len(last_unlock_len),
    .max_unlock_len(max_unlock_len), .ever_locked(ever_locked),
    .unlock_evt(unlock_evt), .relock_evt(relock_evt)
  );

  lock_event_monitor #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(2), .CNT_WIDTH(4)) dut2 (
    .clk_ref(clk_ref), .aresetn(aresetn), .locked_async(la2), .clear(clr2),
    .locked_filt(filt2), .unlocks(unl2), .last_unlock_len(last2),
    .max_unlock_len(max2), .ever_locked(ever2),
    .unlock_evt(uevt2), .relock_evt(revt2)
  );

  always #5 clk_ref = ~clk_ref;

  always @(negedge clk_ref) begin
    if (unlock_evt) n_unl++;
    if (relock_evt) n_rel++;
    if (uevt2) n_unl2++;
    if (revt2) n_rel2++;
  end

  typedef struct {
    int low_len;
    int reps;
    int unl;
    int last;
    int mx;
    int evts;
  } vec_t;
  vec_t vecs[7];

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_ref);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  initial begin
    int n;
    int base_u, base_r;
    vecs[0] = '{10, 20, 0, 0, 0, 0};
    vecs[1] = '{500, 1, 1, 500, 500, 1};
    vecs[2] = '{300, 1, 2, 300, 500, 2};
    vecs[3] = '{900, 1, 3, 900, 900, 3};
    vecs[4] = '{100, 1, 4, 100, 900, 4};
    vecs[5] = '{15, 1, 4, 100, 900, 4};
    vecs[6] = '{16, 1, 5, 16, 900, 5};

    cyc(3);
    chk("rst_filt", 32'(locked_filt), 0);
    chk("rst_unlocks", unlocks, 0);
    chk("rst_last", last_unlock_len, 0);
    chk("rst_max", max_unlock_len, 0);
    chk("rst_ever", 32'(ever_locked), 0);
    aresetn = 1'b1;
    cyc(1000);
    chk("init_filt", 32'(locked_filt), 0);
    chk("init_ever", 32'(ever_locked), 0);

    locked_async = 1'b1;
    n = 0;
    while (!locked_filt && n < 100) begin
      cyc(1);
      n++;
    end
    chk("lock_latency", n, 18);
    cyc(2);
    chk("first_ever", 32'(ever_locked), 1);
    chk("first_unlocks", unlocks, 0);
    chk("first_unl_evts", n_unl, 0);
    chk("first_rel_evts", n_rel, 0);

    foreach (vecs[i]) begin
      repeat (vecs[i].reps) begin
        locked_async = 1'b0;
        cyc(vecs[i].low_len);
        locked_async = 1'b1;
        cyc(40);
      end
      chk($sformatf("vec%0d_unlocks", i), unlocks, vecs[i].unl);
      chk($sformatf("vec%0d_last", i), last_unlock_len, vecs[i].last);
      chk($sformatf("vec%0d_max", i), max_unlock_len, vecs[i].mx);
      chk($sformatf("vec%0d_unl_evts", i), n_unl, vecs[i].evts);
      chk($sformatf("vec%0d_rel_evts", i), n_rel, vecs[i].evts);
      chk($sformatf("vec%0d_filt", i), 32'(locked_filt), 1);
    end

    locked_async = 1'b0;
    cyc(18);
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    chk("clrfall_evt", 32'(unlock_evt), 1);
    chk("clrfall_unlocks", unlocks, 1);
    locked_async = 1'b1;
    cyc(40);
    chk("clrfall_last", last_unlock_len, 19);
    chk("clrfall_max", max_unlock_len, 19);

    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    chk("clr_unlocks", unlocks, 0);
    chk("clr_last", last_unlock_len, 0);
    chk("clr_max", max_unlock_len, 0);
    chk("clr_filt", 32'(locked_filt), 1);
    chk("clr_ever", 32'(ever_locked), 1);

    locked_async = 1'b0;
    cyc(30);
    locked_async = 1'b1;
    cyc(18);
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    chk("clrrise_evt", 32'(relock_evt), 1);
    chk("clrrise_unlocks", unlocks, 0);
    chk("clrrise_last", last_unlock_len, 30);
    chk("clrrise_max", max_unlock_len, 30);

    locked_async = 1'b0;
    cyc(50);
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    chk("clrmid_unlocks", unlocks, 0);
    cyc(29);
    locked_async = 1'b1;
    cyc(40);
    chk("clrmid_last", last_unlock_len, 80);
    chk("clrmid_max", max_unlock_len, 80);
    chk("clrmid_unlocks2", unlocks, 0);

    locked_async = 1'b0;
    cyc(40);
    chk("pre_rst_unlocks", unlocks, 1);
    aresetn = 1'b0;
    #1;
    chk("arst_filt", 32'(locked_filt), 0);
    chk("arst_unlocks", unlocks, 0);
    chk("arst_last", last_unlock_len, 0);
    chk("arst_max", max_unlock_len, 0);
    chk("arst_ever", 32'(ever_locked), 0);
    cyc(2);
    aresetn = 1'b1;
    cyc(5);
    base_u = n_unl;
    base_r = n_rel;
    locked_async = 1'b1;
    cyc(40);
    chk("post_rst_filt", 32'(locked_filt), 1);
    chk("post_rst_ever", 32'(ever_locked), 1);
    chk("post_rst_unlocks", unlocks, 0);
    chk("post_rst_unl_evts", n_unl - base_u, 0);
    chk("post_rst_rel_evts", n_rel - base_r, 0);

    la2 = 1'b1;
    cyc(10);
    repeat (17) begin
      la2 = 1'b0;
      cyc(10);
      la2 = 1'b1;
      cyc(10);
    end
    chk("sat_unlocks", 32'(unl2), 15);
    chk("sat_last10", 32'(last2), 10);
    la2 = 1'b0;
    cyc(20);
    la2 = 1'b1;
    cyc(10);
    chk("sat_last", 32'(last2), 15);
    chk("sat_max", 32'(max2), 15);
    chk("sat_unl_evts", n_unl2, 18);
    chk("sat_rel_evts", n_rel2, 18);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
